// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two request ports, the RAM control strobes, the
//               shared RAM bus and the RAM read-data return path used by
//               ram_arbiter.
//   slave  : arbiter side. It receives the requests and ram_out. It drives the
//            acks, err, rdata, busy, the strobes and bus.
//   master : requester/RAM side. It is the mirror image of slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if;
    // Port 0 (CPU) request
    logic        req0;
    logic        we0;
    logic [11:0] addr0;
    logic [15:0] wdata0;
    // Port 1 (loader/DMA) request
    logic        req1;
    logic        we1;
    logic [11:0] addr1;
    logic [15:0] wdata1;
    // Completion back to the ports
    logic        ack0;
    logic        ack1;
    logic        err;
    logic [15:0] rdata;
    logic        busy;
    // RAM side
    logic        mar_load;
    logic        ram_en;
    logic        ram_load;
    logic [15:0] bus;
    logic [15:0] ram_out;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_out,
        output ack0, ack1, err, rdata, busy,
        output mar_load, ram_en, ram_load, bus
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_out,
        input  ack0, ack1, err, rdata, busy,
        input  mar_load, ram_en, ram_load, bus
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-port round-robin arbiter in front of a single-ported RAM.
//               It sequences the RAM through its MAR load, read enable and
//               write strobes. It completes every request with a single-cycle
//               ack. A request with an out-of-range address is completed
//               straight away with err and never touches the RAM.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               arb (slave) - request ports, completion, RAM strobes/bus
// Parameters  : RAM_DEPTH   - number of valid RAM words
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int unsigned RAM_DEPTH = 256
) (
    input  wire logic       clk,
    input  wire logic       reset,
    ram_arbiter_if.slave    arb
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAR  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    // Transaction context captured at grant
    logic        grant_port;
    logic        last_grant;
    logic        we_lat;
    logic [11:0] addr_lat;
    logic [15:0] wdata_lat;
    logic        oor_flag;
    logic [15:0] rdata_reg;

    // Arbitration result for the current IDLE cycle
    logic        any_req;
    logic        pick;
    logic        pick_we;
    logic [11:0] pick_addr;
    logic [15:0] pick_wdata;
    logic        pick_oor;

    // Decoded outputs
    logic        ack0_d;
    logic        ack1_d;
    logic        err_d;
    logic        busy_d;
    logic        mar_load_d;
    logic        ram_en_d;
    logic        ram_load_d;
    logic [15:0] bus_d;

    // ------------------------------------------------------------------------
    // Round-robin pick. A lone requester always wins. On a tie the port that
    // was not granted last wins.
    // ------------------------------------------------------------------------
    always_comb begin
        any_req    = arb.req0 | arb.req1;
        pick       = (arb.req0 & arb.req1) ? ~last_grant : arb.req1;
        pick_we    = pick ? arb.we1    : arb.we0;
        pick_addr  = pick ? arb.addr1  : arb.addr0;
        pick_wdata = pick ? arb.wdata1 : arb.wdata0;
        pick_oor   = ({20'd0, pick_addr} >= RAM_DEPTH);
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Grant context and read data capture. The context is latched only on the
    // grant edge. Later input changes cannot disturb the transaction.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;         // port 0 wins the first tie
            grant_port <= 1'b0;
            we_lat     <= 1'b0;
            addr_lat   <= 12'd0;
            wdata_lat  <= 16'd0;
            oor_flag   <= 1'b0;
            rdata_reg  <= 16'd0;
        end else begin
            if (state == S_IDLE && any_req) begin
                grant_port <= pick;
                last_grant <= pick;
                we_lat     <= pick_we;
                addr_lat   <= pick_addr;
                wdata_lat  <= pick_wdata;
                oor_flag   <= pick_oor;
            end
            // ram_out holds the word fetched during RD
            if (state == S_CAP) begin
                rdata_reg <= arb.ram_out;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err_d      = 1'b0;
        mar_load_d = 1'b0;
        ram_en_d   = 1'b0;
        ram_load_d = 1'b0;
        bus_d      = 16'd0;
        busy_d     = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_next = pick_oor ? S_DONE : S_MAR;
                end
            end
            S_MAR: begin
                mar_load_d = 1'b1;
                bus_d      = {4'd0, addr_lat};
                state_next = we_lat ? S_WR : S_RD;
            end
            S_RD: begin
                ram_en_d   = 1'b1;
                state_next = S_CAP;
            end
            S_CAP: begin
                state_next = S_DONE;
            end
            S_WR: begin
                ram_load_d = 1'b1;
                bus_d      = wdata_lat;
                state_next = S_DONE;
            end
            S_DONE: begin
                ack0_d     = ~grant_port;
                ack1_d     = grant_port;
                err_d      = oor_flag;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // While reset is high, nothing may reach the RAM or the ports. This
        // also kills ram_load in WR, so the aborted write never lands.
        if (reset) begin
            ack0_d     = 1'b0;
            ack1_d     = 1'b0;
            err_d      = 1'b0;
            busy_d     = 1'b0;
            mar_load_d = 1'b0;
            ram_en_d   = 1'b0;
            ram_load_d = 1'b0;
            bus_d      = 16'd0;
        end
    end

    assign arb.ack0     = ack0_d;
    assign arb.ack1     = ack1_d;
    assign arb.err      = err_d;
    assign arb.busy     = busy_d;
    assign arb.mar_load = mar_load_d;
    assign arb.ram_en   = ram_en_d;
    assign arb.ram_load = ram_load_d;
    assign arb.bus      = bus_d;
    assign arb.rdata    = rdata_reg;

endmodule
`default_nettype wire
